pipe_stall_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It drives the `keep_d` hold inputs of every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and the bubble/flush controls. It resolves three conditions:
- load-use hazards;
- multi-cycle data-memory waits;
- taken branches.

It sits beside the datapath, taking hazard inputs from ID/EX and EX/MEM and handing hold/flush decisions back to the registers.

---
 rtl/pipe_stall_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller: combinational keep_*/flush_* (zero latency) from FSM state RUN/MEM_WAIT and hazard inputs.
// No handshake; memory waits hold every stage until mem_ready_i. Optional forced release: `define MEM_TIMEOUT_EN.
module pipe_stall_ctrl #(
   parameter int R_WIDTH = 5,
   parameter int WAIT_W  = 4,
   parameter int TIMEOUT = 15
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [R_WIDTH-1:0] if_id_rs_i,
   input  logic [R_WIDTH-1:0] if_id_rt_i,
   input  logic               id_ex_mem_read_i,
   input  logic [R_WIDTH-1:0] id_ex_rt_i,
   input  logic               mem_req_i,
   input  logic               mem_ready_i,
   input  logic               branch_taken_i,
   output logic               keep_pc_o,
   output logic               keep_if_id_o,
   output logic               keep_id_ex_o,
   output logic               keep_ex_mem_o,
   output logic               keep_mem_wb_o,
   output logic               flush_id_ex_o,
   output logic               flush_if_id_o,
   output logic [15:0]        stall_cnt_o,
   output logic               mem_err_o
);

   typedef enum logic {S_RUN = 1'b0, S_MEM_WAIT = 1'b1} state_t;

   localparam logic [WAIT_W-1:0] L_TIMEOUT_CNT = WAIT_W'(TIMEOUT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [15:0]       r_stall_cnt;

   logic w_mem_stall;
   logic w_load_use;
   logic w_cnt_at_limit;
   logic w_timeout;
   logic w_release;
   logic w_hold_all;

   assign w_mem_stall    = mem_req_i && !mem_ready_i;
   assign w_load_use     = id_ex_mem_read_i && (id_ex_rt_i != '0) &&
                           ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));
   assign w_cnt_at_limit = (r_wait_cnt == L_TIMEOUT_CNT);

`ifdef MEM_TIMEOUT_EN
   assign w_timeout = (r_state == S_MEM_WAIT) && w_cnt_at_limit && !mem_ready_i;
`else
   assign w_timeout = 1'b0;
   logic w_unused_timeout;
   assign w_unused_timeout = w_cnt_at_limit;
`endif

   // A release cycle drops the memory hold but still honours load-use and branch.
   assign w_release  = (r_state == S_MEM_WAIT) && (mem_ready_i || w_timeout);
   assign w_hold_all = (r_state == S_RUN) ? w_mem_stall : !w_release;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN:      if (w_mem_stall) w_state_nxt = S_MEM_WAIT;
         S_MEM_WAIT: if (w_release)   w_state_nxt = S_RUN;
         default:    w_state_nxt = S_RUN;
      endcase
   end

   always_comb begin
      keep_pc_o     = 1'b0;
      keep_if_id_o  = 1'b0;
      keep_id_ex_o  = 1'b0;
      keep_ex_mem_o = 1'b0;
      keep_mem_wb_o = 1'b0;
      flush_id_ex_o = 1'b0;
      flush_if_id_o = 1'b0;
      if (!rst_i) begin
         if (w_hold_all) begin
            keep_pc_o     = 1'b1;
            keep_if_id_o  = 1'b1;
            keep_id_ex_o  = 1'b1;
            keep_ex_mem_o = 1'b1;
            keep_mem_wb_o = 1'b1;
         end else if (w_load_use) begin
            keep_pc_o     = 1'b1;
            keep_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
         end else if (branch_taken_i) begin
            flush_if_id_o = 1'b1;
         end
      end
   end

   // Held at zero in RUN so each wait starts counting from 0.
   always_ff @(posedge clk_i) begin
      if (rst_i || r_state == S_RUN) begin
         r_wait_cnt <= '0;
      end else begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // keep_pc_o is asserted by every stall kind, so it marks a stalled cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
      end else if (keep_pc_o && r_stall_cnt != 16'hFFFF) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;

`ifdef MEM_TIMEOUT_EN
   logic r_mem_err;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mem_err <= 1'b0;
      end else if (w_timeout) begin
         r_mem_err <= 1'b1;
      end
   end
   assign mem_err_o = r_mem_err;
`else
   assign mem_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with a per-cycle behavioural model and literal spot checks.
module tb_pipe_stall_ctrl;
   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs, rt, ex_rt;
   logic       rd, req, rdy, br;
   logic       k_pc, k_ifid, k_idex, k_exmem, k_memwb, f_idex, f_ifid;
   logic [15:0] cnt;
   logic       err;

   int n_checks = 0;
   int n_errors = 0;
   bit started  = 1'b0;

   pipe_stall_ctrl #(.R_WIDTH(5), .WAIT_W(4), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_i(rst),
      .if_id_rs_i(rs), .if_id_rt_i(rt),
      .id_ex_mem_read_i(rd), .id_ex_rt_i(ex_rt),
      .mem_req_i(req), .mem_ready_i(rdy), .branch_taken_i(br),
      .keep_pc_o(k_pc), .keep_if_id_o(k_ifid), .keep_id_ex_o(k_idex),
      .keep_ex_mem_o(k_exmem), .keep_mem_wb_o(k_memwb),
      .flush_id_ex_o(f_idex), .flush_if_id_o(f_ifid),
      .stall_cnt_o(cnt), .mem_err_o(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: memory outstanding flag, cycles spent waiting, total stalled cycles.
   bit m_waiting = 1'b0;
   int m_wait_cycles = 0;
   int m_stalls = 0;
   bit m_err = 1'b0;

   function automatic bit timed_out();
`ifdef MEM_TIMEOUT_EN
      return m_waiting && (m_wait_cycles % 16 == TIMEOUT - 1) && !rdy;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit mem_hold();
      if (m_waiting) return !(rdy || timed_out());
      return req && !rdy;
   endfunction

   function automatic bit load_use();
      return rd && ex_rt != 0 && (ex_rt == rs || ex_rt == rt);
   endfunction

   always @(negedge clk) begin
      if (started) begin
         bit hold, lu, fb, any;
         hold = !rst && mem_hold();
         lu   = !rst && !hold && load_use();
         fb   = !rst && !hold && !lu && br;
         any  = hold || lu;
         chk("m_keep_pc",     k_pc,    any);
         chk("m_keep_if_id",  k_ifid,  any);
         chk("m_keep_id_ex",  k_idex,  hold);
         chk("m_keep_ex_mem", k_exmem, hold);
         chk("m_keep_mem_wb", k_memwb, hold);
         chk("m_flush_id_ex", f_idex,  lu);
         chk("m_flush_if_id", f_ifid,  fb);
         chk("m_stall_cnt",   cnt,     m_stalls);
         chk("m_mem_err",     err,     m_err);
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         m_waiting = 0; m_wait_cycles = 0; m_stalls = 0; m_err = 0;
      end else begin
         bit stalled, to;
         stalled = mem_hold() || load_use();
         to = timed_out();
         if (stalled && m_stalls < 65535) m_stalls++;
         if (m_waiting) begin
            if (rdy || to) begin
               m_waiting = 0;
               if (to) m_err = 1;
            end else begin
               m_wait_cycles++;
            end
         end else if (req && !rdy) begin
            m_waiting = 1;
            m_wait_cycles = 0;
         end
      end
      started = 1'b1;
   end

   task automatic set_in(input logic r, input logic d, input logic [4:0] x, input logic [4:0] s,
                         input logic [4:0] t, input logic q, input logic y, input logic b);
      rst = r; rd = d; ex_rt = x; rs = s; rt = t; req = q; rdy = y; br = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset with a memory stall presented: outputs must stay low
      set_in(1, 0, 0, 0, 0, 1, 0, 0); #1;
      chk("rst_keep_pc", k_pc, 0);
      chk("rst_keep_mem_wb", k_memwb, 0);
      tick(); tick();
      chk("rst_cnt", cnt, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0); #1; chk("idle_keep", k_pc, 0); tick();

      set_in(0, 1, 5, 5, 0, 0, 0, 0); #1;
      chk("lu_keep_pc", k_pc, 1);
      chk("lu_keep_if_id", k_ifid, 1);
      chk("lu_flush_id_ex", f_idex, 1);
      chk("lu_keep_id_ex", k_idex, 0);
      tick();
      chk("lu_cnt", cnt, 1);
      set_in(0, 0, 0, 5, 0, 0, 0, 0); #1; chk("lu_one_cycle", k_pc, 0); tick();

      set_in(0, 1, 0, 0, 0, 0, 0, 0); #1;
      chk("lu_r0_keep", k_pc, 0);
      chk("lu_r0_flush", f_idex, 0);
      tick();
      chk("lu_r0_cnt", cnt, 1);

      set_in(0, 1, 7, 3, 7, 0, 0, 0); #1; chk("lu_rt_keep", k_ifid, 1); tick();
      chk("lu_rt_cnt", cnt, 2);

      set_in(0, 0, 0, 0, 0, 0, 0, 1); #1;
      chk("br_flush", f_ifid, 1);
      chk("br_keep", k_pc, 0);
      tick();
      chk("br_cnt", cnt, 2);

      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, 0, 1, 0, 0); #1; chk("mw_keep", k_memwb, 1); tick();
      end
      set_in(0, 0, 0, 0, 0, 1, 1, 0); #1; chk("mw_release", k_exmem, 0); tick();
      chk("mw_cnt", cnt, 5);
      set_in(0, 0, 0, 0, 0, 0, 0, 0); #1; chk("mw_run_after", k_pc, 0); tick();

      set_in(0, 0, 0, 0, 0, 1, 1, 0); #1; chk("same_cycle_ready", k_pc, 0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0); #1; chk("same_cycle_run", k_idex, 0); tick();
      chk("same_cycle_cnt", cnt, 5);

      set_in(0, 1, 5, 5, 0, 1, 0, 1); #1;
      chk("prio_keep_id_ex", k_idex, 1);
      chk("prio_flush_if_id", f_ifid, 0);
      chk("prio_flush_id_ex", f_idex, 0);
      tick();
      set_in(0, 1, 5, 5, 0, 1, 1, 1); #1;
      chk("prio_rel_keep_pc", k_pc, 1);
      chk("prio_rel_keep_ex_mem", k_exmem, 0);
      chk("prio_rel_bubble", f_idex, 1);
      chk("prio_rel_no_br", f_ifid, 0);
      tick();
      set_in(0, 0, 0, 5, 0, 0, 0, 1); #1;
      chk("prio_br_after", f_ifid, 1);
      chk("prio_no_keep", k_pc, 0);
      tick();
      chk("prio_cnt", cnt, 7);

      set_in(0, 0, 0, 0, 0, 1, 0, 0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0); #1; chk("wait_hold", k_pc, 1); tick();
      set_in(1, 0, 0, 0, 0, 0, 0, 0); #1; chk("rst_mid_keep", k_memwb, 0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("rst_mid_run", k_pc, 0);
      chk("rst_mid_cnt", cnt, 0);
      tick();

      set_in(0, 0, 0, 0, 0, 1, 0, 0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 19; i++) tick();
`ifdef MEM_TIMEOUT_EN
      chk("long_keep", k_pc, 0);
      chk("long_err", err, 1);
      chk("long_cnt", cnt, 15);
`else
      chk("long_keep", k_pc, 1);
      chk("long_err", err, 0);
      chk("long_cnt", cnt, 20);
`endif
      set_in(0, 0, 0, 0, 0, 0, 1, 0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
`ifdef MEM_TIMEOUT_EN
      chk("err_sticky", err, 1);
`else
      chk("err_tied", err, 0);
`endif
      set_in(1, 0, 0, 0, 0, 0, 0, 0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("err_cleared", err, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
